// File: rtl/mc_controller.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// ready-handshaked memories, illegal/timeout traps and a retired-instruction counter.
module mc_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 8,
  parameter int RETIRE_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [31:0]         i_inst,
  input  logic                i_br_less,
  input  logic                i_br_equal,
  input  logic                i_imem_rdy,
  input  logic                i_dmem_rdy,
  output logic                o_imem_req,
  output logic                o_dmem_req,
  output logic                o_dmem_we,
  output logic                o_ir_we,
  output logic                o_pc_we,
  output logic                o_pc_sel,
  output logic [3:0]          o_alu_op,
  output logic [1:0]          o_alu_a_sel,
  output logic                o_alu_b_sel,
  output logic [2:0]          o_imm_sel,
  output logic [1:0]          o_wb_sel,
  output logic                o_reg_wen,
  output logic                o_br_un,
  output logic                o_retire,
  output logic [RETIRE_W-1:0] o_retire_cnt,
  output logic                o_trap,
  output logic [1:0]          o_trap_cause
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [3:0] {
    C_ILL, C_R, C_IALU, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LOAD, C_STORE
  } cls_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] CAUSE_ILL  = 2'b00;
  localparam logic [1:0] CAUSE_IMEM = 2'b01;
  localparam logic [1:0] CAUSE_DMEM = 2'b10;

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT =
    TIMEOUT_EN ? TIMEOUT_W'(MEM_TIMEOUT - 1) : '0;

  state_t                state, state_next;
  cls_t                  cls;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic [RETIRE_W-1:0]   retire_cnt;
  logic [1:0]            cause_q, cause_next;
  logic [3:0]            alu_fn;
  logic [1:0]            a_sel;
  logic                  b_sel;
  logic [2:0]            imm_sel;
  logic                  taken;
  logic                  wait_expired;
  logic                  mem_wait;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_inst;

  assign opcode      = i_inst[6:0];
  assign funct3      = i_inst[14:12];
  assign unused_inst = ^{i_inst[31], i_inst[29:15], i_inst[11:7]};

  // opcode[1:0] is part of every legal opcode, so a non-11 low pair falls to C_ILL
  always_comb begin
    cls = C_ILL;
    case (opcode)
      OP_R:     cls = C_R;
      OP_IALU:  cls = C_IALU;
      OP_LUI:   cls = C_LUI;
      OP_AUIPC: cls = C_AUIPC;
      OP_JAL:   cls = C_JAL;
      OP_JALR:  if (funct3 == 3'b000) cls = C_JALR;
      OP_BR:    if (funct3[2:1] != 2'b01) cls = C_BR;
      OP_LOAD:  cls = C_LOAD;
      OP_STORE: cls = C_STORE;
      default:  cls = C_ILL;
    endcase
  end

  always_comb begin
    alu_fn = ALU_ADD;
    if (cls == C_R || cls == C_IALU) begin
      case (funct3)
        3'b000:  alu_fn = (cls == C_R && i_inst[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_fn = ALU_SLL;
        3'b010:  alu_fn = ALU_SLT;
        3'b011:  alu_fn = ALU_SLTU;
        3'b100:  alu_fn = ALU_XOR;
        3'b101:  alu_fn = i_inst[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_fn = ALU_OR;
        default: alu_fn = ALU_AND;
      endcase
    end
  end

  always_comb begin
    a_sel   = A_RS1;
    b_sel   = 1'b1;
    imm_sel = IMM_I;
    case (cls)
      C_R:     b_sel = 1'b0;
      C_LUI:   begin a_sel = A_ZERO; imm_sel = IMM_U; end
      C_AUIPC: begin a_sel = A_PC;   imm_sel = IMM_U; end
      C_JAL:   begin a_sel = A_PC;   imm_sel = IMM_J; end
      C_BR:    begin a_sel = A_PC;   imm_sel = IMM_B; end
      C_STORE: imm_sel = IMM_S;
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:         taken = i_br_equal;
      3'b001:         taken = ~i_br_equal;
      3'b100, 3'b110: taken = i_br_less;
      3'b101, 3'b111: taken = ~i_br_less;
      default:        taken = 1'b0;
    endcase
  end

  assign wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);
  assign mem_wait     = (state == S_FETCH && !i_imem_rdy) || (state == S_MEM && !i_dmem_rdy);

  // Everything is gated by i_reset so outputs drop the instant reset rises.
  always_comb begin
    state_next  = state;
    cause_next  = cause_q;
    o_imem_req  = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = 1'b0;
    o_alu_op    = ALU_ADD;
    o_alu_a_sel = A_RS1;
    o_alu_b_sel = 1'b0;
    o_imm_sel   = IMM_I;
    o_wb_sel    = WB_MEM;
    o_reg_wen   = 1'b0;
    o_br_un     = 1'b0;
    o_retire    = 1'b0;
    o_trap      = 1'b0;
    if (!i_reset) begin
      case (state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          if (i_imem_rdy) begin
            o_ir_we    = 1'b1;
            state_next = S_DECODE;
          end else if (wait_expired) begin
            state_next = S_TRAP;
            cause_next = CAUSE_IMEM;
          end
        end
        S_DECODE: begin
          if (cls == C_ILL) begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILL;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          o_alu_op    = alu_fn;
          o_alu_a_sel = a_sel;
          o_alu_b_sel = b_sel;
          o_imm_sel   = imm_sel;
          state_next  = S_FETCH;
          case (cls)
            C_R, C_IALU, C_LUI, C_AUIPC: begin
              o_reg_wen = 1'b1;
              o_wb_sel  = WB_ALU;
              o_pc_we   = 1'b1;
              o_retire  = 1'b1;
            end
            C_JAL, C_JALR: begin
              o_reg_wen = 1'b1;
              o_wb_sel  = WB_PC4;
              o_pc_we   = 1'b1;
              o_pc_sel  = 1'b1;
              o_retire  = 1'b1;
            end
            C_BR: begin
              o_pc_we  = 1'b1;
              o_pc_sel = taken;
              o_br_un  = funct3[1];
              o_retire = 1'b1;
            end
            C_LOAD, C_STORE: state_next = S_MEM;
            default: begin
              state_next = S_TRAP;
              cause_next = CAUSE_ILL;
            end
          endcase
        end
        S_MEM: begin
          o_alu_op    = alu_fn;
          o_alu_a_sel = a_sel;
          o_alu_b_sel = b_sel;
          o_imm_sel   = imm_sel;
          o_dmem_req  = 1'b1;
          o_dmem_we   = (cls == C_STORE);
          if (i_dmem_rdy) begin
            if (cls == C_STORE) begin
              o_pc_we    = 1'b1;
              o_retire   = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end else if (wait_expired) begin
            state_next = S_TRAP;
            cause_next = CAUSE_DMEM;
          end
        end
        S_WB: begin
          o_reg_wen  = 1'b1;
          o_wb_sel   = WB_MEM;
          o_pc_we    = 1'b1;
          o_retire   = 1'b1;
          state_next = S_FETCH;
        end
        default: o_trap = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_FETCH;
      cause_q    <= '0;
      wait_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_wait)
        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      if (o_retire)
        retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

  assign o_retire_cnt = retire_cnt;
  assign o_trap_cause = cause_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: expected control vectors are queued as each
// step is driven and popped for comparison when the DUT output is sampled.
module tb_mc_controller;

  localparam int RW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [31:0]   i_inst;
  logic          i_br_less, i_br_equal, i_imem_rdy, i_dmem_rdy;
  logic          o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_we, o_pc_sel;
  logic [3:0]    o_alu_op;
  logic [1:0]    o_alu_a_sel;
  logic          o_alu_b_sel;
  logic [2:0]    o_imm_sel;
  logic [1:0]    o_wb_sel;
  logic          o_reg_wen, o_br_un, o_retire;
  logic [RW-1:0] o_retire_cnt;
  logic          o_trap;
  logic [1:0]    o_trap_cause;

  mc_controller #(.MEM_TIMEOUT(16), .TIMEOUT_W(8), .RETIRE_W(RW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_inst(i_inst),
    .i_br_less(i_br_less), .i_br_equal(i_br_equal),
    .i_imem_rdy(i_imem_rdy), .i_dmem_rdy(i_dmem_rdy),
    .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
    .o_alu_op(o_alu_op), .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel),
    .o_imm_sel(o_imm_sel), .o_wb_sel(o_wb_sel), .o_reg_wen(o_reg_wen),
    .o_br_un(o_br_un), .o_retire(o_retire), .o_retire_cnt(o_retire_cnt),
    .o_trap(o_trap), .o_trap_cause(o_trap_cause)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel;
    logic [3:0] alu_op;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [2:0] imm_sel;
    logic [1:0] wb_sel;
    logic       reg_wen, br_un, retire, trap;
  } ctl_t;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  tests = 0;
  int  fails = 0;
  int  exp_cnt = 0;

  function automatic ctl_t obs();
    ctl_t c;
    c.imem_req = o_imem_req; c.dmem_req = o_dmem_req; c.dmem_we = o_dmem_we;
    c.ir_we    = o_ir_we;    c.pc_we    = o_pc_we;    c.pc_sel  = o_pc_sel;
    c.alu_op   = o_alu_op;   c.a_sel    = o_alu_a_sel; c.b_sel  = o_alu_b_sel;
    c.imm_sel  = o_imm_sel;  c.wb_sel   = o_wb_sel;   c.reg_wen = o_reg_wen;
    c.br_un    = o_br_un;    c.retire   = o_retire;   c.trap    = o_trap;
    return c;
  endfunction

  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c = '0;
    c.imem_req = 1'b1; c.ir_we = rdy;
    return c;
  endfunction

  function automatic ctl_t c_alu(input logic [3:0] op, input logic [1:0] a, input logic b,
                                 input logic [2:0] imm);
    ctl_t c = '0;
    c.alu_op = op; c.a_sel = a; c.b_sel = b; c.imm_sel = imm;
    c.wb_sel = 2'b01; c.reg_wen = 1'b1; c.pc_we = 1'b1; c.retire = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_jump(input logic [1:0] a, input logic [2:0] imm);
    ctl_t c = '0;
    c.a_sel = a; c.b_sel = 1'b1; c.imm_sel = imm; c.wb_sel = 2'b10;
    c.reg_wen = 1'b1; c.pc_we = 1'b1; c.pc_sel = 1'b1; c.retire = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_branch(input logic tk, input logic un);
    ctl_t c = '0;
    c.a_sel = 2'b01; c.b_sel = 1'b1; c.imm_sel = 3'b010;
    c.pc_we = 1'b1; c.pc_sel = tk; c.br_un = un; c.retire = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_addr(input logic store);
    ctl_t c = '0;
    c.b_sel = 1'b1; c.imm_sel = store ? 3'b001 : 3'b000;
    return c;
  endfunction

  function automatic ctl_t c_mem(input logic store, input logic rdy);
    ctl_t c = c_addr(store);
    c.dmem_req = 1'b1; c.dmem_we = store;
    c.pc_we = store & rdy; c.retire = store & rdy;
    return c;
  endfunction

  function automatic ctl_t c_wb();
    ctl_t c = '0;
    c.reg_wen = 1'b1; c.pc_we = 1'b1; c.retire = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_trap();
    ctl_t c = '0;
    c.trap = 1'b1;
    return c;
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic compare(input logic [31:0] got);
    sb_t e;
    e = sb_q.pop_front();
    tests++;
    assert (got === e.val) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic chk_ctl(input string tag, input ctl_t c);
    push(tag, {10'd0, c});
    #1;
    compare({10'd0, obs()});
  endtask

  task automatic chk_cnt(input string tag);
    push(tag, 32'(exp_cnt));
    compare(32'(o_retire_cnt));
  endtask

  task automatic chk_trap(input string tag, input logic [1:0] cause);
    chk_ctl({tag, ".trap"}, c_trap());
    push({tag, ".cause"}, {30'd0, cause});
    compare({30'd0, o_trap_cause});
  endtask

  task automatic retire_one();
    exp_cnt = (exp_cnt + 1) % (1 << RW);
  endtask

  task automatic do_reset(input string tag);
    i_reset = 1'b1; i_imem_rdy = 1'b1; i_dmem_rdy = 1'b1;
    chk_ctl({tag, ".ctl"}, '0);
    exp_cnt = 0;
    chk_cnt({tag, ".cnt"});
    push({tag, ".cause"}, 32'd0);
    compare({30'd0, o_trap_cause});
    tick();
    chk_ctl({tag, ".hold"}, '0);
    tick();
    i_reset = 1'b0; i_imem_rdy = 1'b0; i_dmem_rdy = 1'b0;
  endtask

  task automatic fetch_decode(input string tag, input logic [31:0] inst, input logic less,
                              input logic eq, input int fetch_wait);
    for (int i = 0; i < fetch_wait; i++) begin
      i_imem_rdy = 1'b0;
      chk_ctl({tag, ".fwait"}, c_fetch(1'b0));
      tick();
    end
    i_inst = inst; i_br_less = less; i_br_equal = eq; i_imem_rdy = 1'b1;
    chk_ctl({tag, ".fetch"}, c_fetch(1'b1));
    tick();
    i_imem_rdy = 1'b0;
    chk_ctl({tag, ".decode"}, '0);
    tick();
  endtask

  task automatic run_simple(input string tag, input logic [31:0] inst, input logic less,
                            input logic eq, input ctl_t ex, input int fetch_wait);
    fetch_decode(tag, inst, less, eq, fetch_wait);
    chk_ctl({tag, ".exec"}, ex);
    tick();
    retire_one();
    chk_cnt({tag, ".cnt"});
  endtask

  task automatic run_mem(input string tag, input logic [31:0] inst, input logic store,
                         input int delay);
    fetch_decode(tag, inst, 1'b0, 1'b0, 0);
    chk_ctl({tag, ".exec"}, c_addr(store));
    tick();
    for (int i = 0; i < delay; i++) begin
      i_dmem_rdy = 1'b0;
      chk_ctl({tag, ".mwait"}, c_mem(store, 1'b0));
      tick();
    end
    i_dmem_rdy = 1'b1;
    chk_ctl({tag, ".mem"}, c_mem(store, 1'b1));
    tick();
    i_dmem_rdy = 1'b0;
    if (!store) begin
      chk_ctl({tag, ".wb"}, c_wb());
      tick();
    end
    retire_one();
    chk_cnt({tag, ".cnt"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0; i_inst = '0; i_br_less = 1'b0; i_br_equal = 1'b0;
    i_imem_rdy = 1'b0; i_dmem_rdy = 1'b0;
    #1;
    do_reset("reset0");

    run_simple("addi",    32'h00500093, 0, 0, c_alu(4'd0, 2'b00, 1'b1, 3'b000), 0);
    run_simple("srai",    32'h4020D093, 0, 0, c_alu(4'd9, 2'b00, 1'b1, 3'b000), 0);
    run_simple("addi400", 32'h40000093, 0, 0, c_alu(4'd0, 2'b00, 1'b1, 3'b000), 0);
    run_simple("sub",     32'h40208033, 0, 0, c_alu(4'd1, 2'b00, 1'b0, 3'b000), 0);
    run_simple("sltu",    32'h0020B0B3, 0, 0, c_alu(4'd3, 2'b00, 1'b0, 3'b000), 0);
    run_simple("lui",     32'h123450B7, 0, 0, c_alu(4'd0, 2'b10, 1'b1, 3'b011), 0);
    run_simple("auipc",   32'h00001097, 0, 0, c_alu(4'd0, 2'b01, 1'b1, 3'b011), 0);
    run_simple("bge",     32'h0020D063, 1, 0, c_branch(1'b0, 1'b0), 0);
    run_simple("bgeu",    32'h0020F063, 0, 0, c_branch(1'b1, 1'b1), 0);
    run_simple("beq",     32'h00208063, 0, 1, c_branch(1'b1, 1'b0), 0);
    run_simple("bne",     32'h00209063, 0, 1, c_branch(1'b0, 1'b0), 0);
    run_simple("bltu",    32'h0020E063, 1, 0, c_branch(1'b1, 1'b1), 0);
    run_simple("jal",     32'h008000EF, 0, 0, c_jump(2'b01, 3'b100), 0);
    run_simple("jalr",    32'h000080E7, 0, 0, c_jump(2'b00, 3'b000), 0);
    run_mem("lw", 32'h0000A083, 1'b0, 3);
    // Sixteenth retirement takes the 4-bit count from all-ones back to zero.
    run_mem("sw_wrap", 32'h0010A023, 1'b1, 0);

    run_simple("addi_pre", 32'h00500093, 0, 0, c_alu(4'd0, 2'b00, 1'b1, 3'b000), 0);
    fetch_decode("sw_abort", 32'h0010A023, 0, 0, 0);
    chk_ctl("sw_abort.exec", c_addr(1'b1));
    tick();
    i_dmem_rdy = 1'b0;
    chk_ctl("sw_abort.mem", c_mem(1'b1, 1'b0));
    do_reset("rst_mid");
    run_simple("addi_post", 32'h00500093, 0, 0, c_alu(4'd0, 2'b00, 1'b1, 3'b000), 0);

    fetch_decode("ill0", 32'h00000000, 0, 0, 0);
    chk_trap("ill0", 2'b00);
    chk_cnt("ill0.cnt");
    for (int i = 0; i < 3; i++) begin
      tick();
      i_imem_rdy = i[0];
      chk_trap("ill0.sticky", 2'b00);
    end

    do_reset("rst_br");
    fetch_decode("ill_br", 32'h0020A063, 0, 0, 0);
    chk_trap("ill_br", 2'b00);
    do_reset("rst_jalr");
    fetch_decode("ill_jalr", 32'h000090E7, 0, 0, 0);
    chk_trap("ill_jalr", 2'b00);

    do_reset("rst_ito");
    for (int i = 0; i < 16; i++) begin
      chk_ctl("ito.wait", c_fetch(1'b0));
      tick();
    end
    chk_trap("ito", 2'b01);
    i_imem_rdy = 1'b1;
    tick();
    chk_trap("ito.sticky", 2'b01);
    tick();
    i_imem_rdy = 1'b0;
    chk_trap("ito.sticky2", 2'b01);

    do_reset("rst_lim");
    run_simple("addi_lim", 32'h00500093, 0, 0, c_alu(4'd0, 2'b00, 1'b1, 3'b000), 15);

    fetch_decode("dto", 32'h0000A083, 0, 0, 0);
    chk_ctl("dto.exec", c_addr(1'b0));
    tick();
    for (int i = 0; i < 16; i++) begin
      chk_ctl("dto.wait", c_mem(1'b0, 1'b0));
      tick();
    end
    chk_trap("dto", 2'b10);
    chk_cnt("dto.cnt");

    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
